// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB widths, source indices and round-robin helper
// Defines `ID_WIDTH, `VAL_WIDTH, `CDB_SRC_ALU and `CDB_SRC_LSB for the RS, LSB and ROB.
`ifndef CDB_DEFINES_SVH
`define CDB_DEFINES_SVH
`define ID_WIDTH    4
`define VAL_WIDTH   32
`define CDB_SRC_ALU 0
`define CDB_SRC_LSB 1
`endif

package cdb_arbiter_pkg;
    localparam int CDB_ID_WIDTH  = `ID_WIDTH;
    localparam int CDB_VAL_WIDTH = `VAL_WIDTH;
    localparam int CDB_NUM_SRC   = 2;
    localparam int CDB_DEPTH     = 4;

    function automatic int rr_next(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO feeding the CDB arbiter
module cdb_src_fifo #(
    parameter int DEPTH     = 4,
    parameter int ID_WIDTH  = 4,
    parameter int VAL_WIDTH = 32,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 push,
    input  logic [ID_WIDTH-1:0]  push_lab,
    input  logic [VAL_WIDTH-1:0] push_val,
    input  logic                 pop,
    output logic [ID_WIDTH-1:0]  head_lab,
    output logic [VAL_WIDTH-1:0] head_val,
    output logic [CNT_W-1:0]     count,
    output logic                 full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_WIDTH-1:0]  lab_mem [DEPTH];
    logic [VAL_WIDTH-1:0] val_mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign do_push  = push && (!full || do_pop);
    assign head_lab = lab_mem[rd_ptr];
    assign head_val = val_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_in && rdy_in && !flush && do_push) begin
            lab_mem[wr_ptr] <= push_lab;
            val_mem[wr_ptr] <= push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the CDB between result sources
// Define CDB_BYPASS_EN to let a push into an empty FIFO win the CDB in its own cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int  NUM_SRC   = CDB_NUM_SRC,
    parameter int  DEPTH     = CDB_DEPTH,
    parameter int  ID_WIDTH  = CDB_ID_WIDTH,
    parameter int  VAL_WIDTH = CDB_VAL_WIDTH,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    src_lab,
    input  logic [NUM_SRC*VAL_WIDTH-1:0]   src_val,
    output logic [NUM_SRC-1:0]             src_full,
    output logic                           cdb_ready,
    output logic [ID_WIDTH-1:0]            cdb_lab,
    output logic [VAL_WIDTH-1:0]           cdb_val,
    output logic [SRC_W-1:0]               cdb_src,
    output logic                           overflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_WIDTH-1:0]  lab_in   [NUM_SRC];
    logic [VAL_WIDTH-1:0] val_in   [NUM_SRC];
    logic [ID_WIDTH-1:0]  head_lab [NUM_SRC];
    logic [VAL_WIDTH-1:0] head_val [NUM_SRC];
    logic [CNT_W-1:0]     count    [NUM_SRC];
    logic [NUM_SRC-1:0]   push_req, empty, cand, pop, fifo_push, drop;
    logic [SRC_W-1:0]     rr_ptr, grant_idx;
    logic                 grant_any, grant_byp;
    logic [ID_WIDTH-1:0]  sel_lab;
    logic [VAL_WIDTH-1:0] sel_val;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign lab_in[i]   = src_lab[i*ID_WIDTH +: ID_WIDTH];
        assign val_in[i]   = src_val[i*VAL_WIDTH +: VAL_WIDTH];
        assign push_req[i] = src_valid[i] && (lab_in[i] != '0);
        assign empty[i]    = (count[i] == '0);
`ifdef CDB_BYPASS_EN
        assign cand[i]     = !empty[i] || push_req[i];
`else
        assign cand[i]     = !empty[i];
`endif
        assign pop[i]       = grant_any && (grant_idx == SRC_W'(i)) && !empty[i];
        assign fifo_push[i] = push_req[i] && !(grant_byp && (grant_idx == SRC_W'(i)));
        assign drop[i]      = push_req[i] && src_full[i] && !pop[i];

        cdb_src_fifo #(
            .DEPTH     (DEPTH),
            .ID_WIDTH  (ID_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .CNT_W     (CNT_W)
        ) u_fifo (
            .clk      (clk),
            .rst_in   (rst_in),
            .rdy_in   (rdy_in),
            .flush    (flush),
            .push     (fifo_push[i]),
            .push_lab (lab_in[i]),
            .push_val (val_in[i]),
            .pop      (pop[i]),
            .head_lab (head_lab[i]),
            .head_val (head_val[i]),
            .count    (count[i]),
            .full     (src_full[i])
        );
    end

    // First candidate at or after rr_ptr, wrapping, wins the bus.
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx       = '0;
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

`ifdef CDB_BYPASS_EN
    assign grant_byp = grant_any && empty[grant_idx];
`else
    assign grant_byp = 1'b0;
`endif

    always_comb begin
        sel_lab = head_lab[grant_idx];
        sel_val = head_val[grant_idx];
`ifdef CDB_BYPASS_EN
        if (grant_byp) begin
            sel_lab = lab_in[grant_idx];
            sel_val = val_in[grant_idx];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rr_ptr    <= '0;
            cdb_ready <= 1'b0;
            cdb_lab   <= '0;
            cdb_val   <= '0;
            cdb_src   <= '0;
            overflow  <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                rr_ptr    <= '0;
                cdb_ready <= 1'b0;
                cdb_lab   <= '0;
                cdb_val   <= '0;
                cdb_src   <= '0;
            end else begin
                cdb_ready <= grant_any;
                cdb_lab   <= grant_any ? sel_lab : '0;
                cdb_val   <= grant_any ? sel_val : '0;
                cdb_src   <= grant_any ? grant_idx : '0;
                if (grant_any) rr_ptr <= SRC_W'(rr_next(int'(grant_idx), NUM_SRC));
                if (|drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter (default and CDB_BYPASS_EN builds)
module tb_cdb_arbiter;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT        = BYP ? 1 : 2;
    localparam int OVF_PUSHES = BYP ? 10 : 9;
    localparam int FULL_IDX   = BYP ? 7 : 6;
    localparam int DROP_IDX   = OVF_PUSHES - 1;
    localparam int FL_CYC     = BYP ? 3 : 4;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic [1:0]  src_valid;
    logic [7:0]  src_lab;
    logic [63:0] src_val;
    logic [1:0]  src_full;
    logic        cdb_ready;
    logic [3:0]  cdb_lab;
    logic [31:0] cdb_val;
    logic [0:0]  cdb_src;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [35:0] exp_alu [$];
    logic [35:0] exp_lsb [$];
    logic [3:0]  obs [$];
    logic        rdy_at_edge = 1'b0;

    cdb_arbiter dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .src_valid (src_valid),
        .src_lab   (src_lab),
        .src_val   (src_val),
        .src_full  (src_full),
        .cdb_ready (cdb_ready),
        .cdb_lab   (cdb_lab),
        .cdb_val   (cdb_val),
        .cdb_src   (cdb_src),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic [3:0] la, input logic [31:0] xa,
                         input logic vl, input logic [3:0] ll, input logic [31:0] xl,
                         input bit record);
        src_valid = {vl, va};
        src_lab   = {ll, la};
        src_val   = {xl, xa};
        if (record) begin
            if (va) exp_alu.push_back({la, xa});
            if (vl) exp_lsb.push_back({ll, xl});
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        exp_alu.delete();
        exp_lsb.delete();
        obs.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cdb_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, cdb_ready, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_alu.size() + exp_lsb.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, exp_alu.size() + exp_lsb.size(), 0);
    endtask

    task automatic check_obs(input string tag, input int n, input logic [31:0] seq);
        chk({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < n; i++)
            if (i < obs.size()) chk(tag, obs[i], seq[4*i +: 4]);
    endtask

    always @(posedge clk) rdy_at_edge <= rdy_in && !rst_in;

    // Scoreboard: each fresh broadcast must match the head of its source's queue.
    always @(negedge clk) begin : mon
        logic [35:0] e;
        if (rdy_at_edge && cdb_ready === 1'b1) begin
            obs.push_back(cdb_lab);
            if (cdb_src == 1'b0 && exp_alu.size() != 0) begin
                e = exp_alu.pop_front();
                chk("bcast_alu_lab", cdb_lab, e[35:32]);
                chk("bcast_alu_val", cdb_val, e[31:0]);
            end else if (cdb_src == 1'b1 && exp_lsb.size() != 0) begin
                e = exp_lsb.pop_front();
                chk("bcast_lsb_lab", cdb_lab, e[35:32]);
                chk("bcast_lsb_val", cdb_val, e[31:0]);
            end else begin
                chk("spurious_bcast", cdb_ready, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rl;
        logic [11:0] hist;

        do_reset();
        chk("rst_ready", cdb_ready, 1'b0);
        chk("rst_lab", cdb_lab, 4'd0);
        chk("rst_val", cdb_val, 32'd0);
        chk("rst_src", cdb_src, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_full", src_full, 2'b00);

        // Label 0 is silently discarded.
        drive(1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("lab0_ovf", overflow, 1'b0);
        chk("lab0_ready", cdb_ready, 1'b0);

        // Single push latency.
        drive(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'd0, 1'b1);
        tick();
        idle();
        chk("single_e0_ready", cdb_ready, BYP);
        for (int c = 1; c < LAT; c++) tick();
        chk("single_ready", cdb_ready, 1'b1);
        chk("single_lab", cdb_lab, 4'd3);
        chk("single_val", cdb_val, 32'h1234_5678);
        chk("single_src", cdb_src, 1'b0);
        tick();
        chk("single_ready_off", cdb_ready, 1'b0);
        chk("single_lab_off", cdb_lab, 4'd0);
        chk("single_val_off", cdb_val, 32'd0);
        drain("single_drain");

        // Simultaneous pushes; rr_ptr must return to ALU for the second pair.
        do_reset();
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd1, ra, 1'b1, 4'd2, rl, 1'b1);
        tick();
        idle();
        wait_ready("simul_start");
        tick();
        chk("simul_consec", cdb_ready, 1'b1);
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd9, ra, 1'b1, 4'd10, rl, 1'b1);
        tick();
        idle();
        drain("simul_drain");
        check_obs("simul_order", 4, 32'h0000_A921);

        // Fairness with both sources streaming.
        do_reset();
        hist = '0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                ra = $urandom; rl = $urandom;
                drive(1'b1, 4'(c + 1), ra, 1'b1, 4'(c + 5), rl, 1'b1);
            end else begin
                idle();
            end
            tick();
            hist[c] = cdb_ready;
        end
        chk("fair_ready_pattern", hist, 12'h0FF << (LAT - 1));
        drain("fair_drain");
        check_obs("fair_order", 8, 32'h8473_6251);

        // Fill the ALU FIFO until a push is dropped.
        do_reset();
        for (int i = 0; i < OVF_PUSHES; i++) begin
            ra = $urandom; rl = $urandom;
            drive(1'b1, 4'(i + 1), ra, (i < 5), 4'(11 + i), rl, 1'b0);
            if (i != DROP_IDX) exp_alu.push_back({4'(i + 1), ra});
            if (i < 5) exp_lsb.push_back({4'(11 + i), rl});
            tick();
            chk("ovf_full_alu", src_full[0], (i >= FULL_IDX));
            chk("ovf_full_lsb", src_full[1], 1'b0);
            chk("ovf_flag", overflow, (i >= DROP_IDX));
        end
        idle();
        drain("ovf_drain");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ovf_sticky_flush", overflow, 1'b1);

        // Flush mid-stream: queued and in-flight results are discarded.
        do_reset();
        for (int c = 0; c < FL_CYC; c++) begin
            ra = $urandom; rl = $urandom;
            drive(1'b1, 4'(c + 1), ra, 1'b1, 4'(c + 8), rl, 1'b1);
            tick();
        end
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd14, ra, 1'b1, 4'd15, rl, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        exp_alu.delete();
        exp_lsb.delete();
        chk("flush_ready", cdb_ready, 1'b0);
        chk("flush_lab", cdb_lab, 4'd0);
        chk("flush_full", src_full, 2'b00);
        for (int c = 0; c < 6; c++) tick();
        obs.delete();
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd5, ra, 1'b1, 4'd6, rl, 1'b1);
        tick();
        idle();
        drain("flush_resume_drain");
        check_obs("flush_resume_order", 2, 32'h0000_0065);

        // Freeze with rdy_in low: outputs hold, pushes ignored.
        do_reset();
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd1, ra, 1'b1, 4'd2, rl, 1'b1);
        tick();
        rdy_in = 1'b0;
        ra = $urandom; rl = $urandom;
        drive(1'b1, 4'd7, ra, 1'b1, 4'd8, rl, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("frz_ready", cdb_ready, BYP);
            chk("frz_lab", cdb_lab, BYP ? 4'd1 : 4'd0);
            chk("frz_full", src_full, 2'b00);
        end
        rdy_in = 1'b1;
        idle();
        tick();
        chk("frz_resume_ready", cdb_ready, 1'b1);
        chk("frz_resume_lab", cdb_lab, BYP ? 4'd2 : 4'd1);
        drain("frz_drain");
        check_obs("frz_order", 2, 32'h0000_0021);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
